redmule_mx_slot_ctrl: RTL and testbench

//  Front-end slot controller for the shared MX decoder path. Buffers X and W mantissa

---
 rtl/redmule_pkg.sv | 14 +
 rtl/redmule_mx_slot.sv | 148 ++++++++++++++
 rtl/redmule_mx_slot_chk.sv | 18 +
 rtl/redmule_mx_slot_ctrl.sv | 90 +++++++++
 tb/tb_redmule_mx_slot_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE MX front-end.
// Holds the default slot depth and the per-stream slot status flags.
package redmule_pkg;

    localparam int unsigned MX_SLOT_DEPTH = 2;
    localparam int unsigned MX_X_EXP_W    = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic exp_valid;
    } mx_slot_flags_t;

endpackage

// File: rtl/redmule_mx_slot.sv
// One MX stream slot: mantissa FIFO, shared-exponent register with reuse counter,
// and an exponent-starvation counter built only when REDMULE_MX_SLOT_PERF_EN is defined.
module redmule_mx_slot
    import redmule_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned DEPTH     = MX_SLOT_DEPTH,
    parameter int unsigned EXP_REUSE = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear,
    input  logic              enable,
    input  logic              man_valid,
    output logic              man_ready,
    input  logic [DATA_W-1:0] man_data,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [EXP_W-1:0]  exp_data,
    output logic              slot_valid,
    output logic              slot_exp_valid,
    output logic [DATA_W-1:0] slot_data,
    output logic [EXP_W-1:0]  slot_exp,
    input  logic              consume,
    output logic [31:0]       stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RU_W  = (EXP_REUSE > 1) ? $clog2(EXP_REUSE) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [RU_W-1:0]  RU_LAST  = RU_W'(EXP_REUSE - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              exp_valid_r;
    logic [EXP_W-1:0]  exp_r;
    logic [RU_W-1:0]   reuse_cnt_r;

    mx_slot_flags_t flags_s;
    logic           push_s;
    logic           pop_s;
    logic           exp_load_s;
    logic           exp_release_s;

    // Handshakes depend on registered state only; a pop never reopens ready in the same cycle.
    always_comb begin
        flags_s.empty     = (count_r == {CNT_W{1'b0}});
        flags_s.full      = (count_r == FULL_CNT);
        flags_s.exp_valid = exp_valid_r;

        man_ready      = enable & ~flags_s.full;
        exp_ready      = enable & ~flags_s.exp_valid;
        slot_valid     = enable & ~flags_s.empty;
        slot_exp_valid = enable & flags_s.exp_valid;
        slot_data      = mem_r[rd_ptr_r];
        slot_exp       = exp_r;

        push_s        = man_valid & man_ready;
        pop_s         = consume & slot_valid & slot_exp_valid;
        exp_load_s    = exp_valid & exp_ready;
        exp_release_s = pop_s & (reuse_cnt_r == RU_LAST);
    end

    // Mantissa FIFO storage, pointers (power-of-two depth wraps naturally) and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {DATA_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {DATA_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= man_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Exponent register and reuse counter; a released exponent refills one cycle later at the earliest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_valid_r <= 1'b0;
            exp_r       <= {EXP_W{1'b0}};
            reuse_cnt_r <= {RU_W{1'b0}};
        end else if (clear) begin
            exp_valid_r <= 1'b0;
            exp_r       <= {EXP_W{1'b0}};
            reuse_cnt_r <= {RU_W{1'b0}};
        end else begin
            if (exp_load_s) begin
                exp_valid_r <= 1'b1;
                exp_r       <= exp_data;
            end else if (exp_release_s) begin
                exp_valid_r <= 1'b0;
            end
            if (pop_s) begin
                reuse_cnt_r <= exp_release_s ? {RU_W{1'b0}} : reuse_cnt_r + RU_W'(1);
            end
        end
    end

`ifdef REDMULE_MX_SLOT_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where mantissa data waits on a missing exponent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'd0;
        end else if (clear) begin
            stall_cnt_r <= 32'd0;
        end else if (!flags_s.empty && !flags_s.exp_valid && enable && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

`ifdef REDMULE_MX_SLOT_ASSERT
    redmule_mx_slot_chk u_chk (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .consume        (consume),
        .slot_valid     (slot_valid),
        .slot_exp_valid (slot_exp_valid)
    );
`endif

endmodule

// File: rtl/redmule_mx_slot_chk.sv
// Protocol checker for one MX slot stream: a consume must only hit a complete slot.
// Built only when REDMULE_MX_SLOT_ASSERT is defined; the slot instantiates it in that case.
`ifdef REDMULE_MX_SLOT_ASSERT
module redmule_mx_slot_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic consume,
    input logic slot_valid,
    input logic slot_exp_valid
);

    // A consume on an incomplete slot is dropped by the slot, but it is still an arbiter bug.
    consume_on_complete_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        consume |-> (slot_valid && slot_exp_valid))
    else $error("redmule_mx_slot: consume while slot or exponent not valid");

endmodule
`endif

// File: rtl/redmule_mx_slot_ctrl.sv
// MX decoder front-end: pairs X/W mantissa beats with their shared-scale exponents.
// Optional stall counters are built when REDMULE_MX_SLOT_PERF_EN is defined.
module redmule_mx_slot_ctrl
    import redmule_pkg::*;
#(
    parameter int unsigned MX_DATA_W       = 256,
    parameter int unsigned MX_EXP_VECTOR_W = 32,
    parameter int unsigned SLOT_DEPTH      = MX_SLOT_DEPTH,
    parameter int unsigned X_EXP_REUSE     = 1,
    parameter int unsigned W_EXP_REUSE     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       mx_enable_i,
    input  logic                       x_man_valid_i,
    output logic                       x_man_ready_o,
    input  logic [MX_DATA_W-1:0]       x_man_data_i,
    input  logic                       x_exp_valid_i,
    output logic                       x_exp_ready_o,
    input  logic [MX_X_EXP_W-1:0]      x_exp_data_i,
    input  logic                       w_man_valid_i,
    output logic                       w_man_ready_o,
    input  logic [MX_DATA_W-1:0]       w_man_data_i,
    input  logic                       w_exp_valid_i,
    output logic                       w_exp_ready_o,
    input  logic [MX_EXP_VECTOR_W-1:0] w_exp_data_i,
    output logic                       x_slot_valid_o,
    output logic                       x_slot_exp_valid_o,
    output logic [MX_DATA_W-1:0]       x_slot_data_o,
    output logic [MX_X_EXP_W-1:0]      x_slot_exp_o,
    output logic                       w_slot_valid_o,
    output logic                       w_slot_exp_valid_o,
    output logic [MX_DATA_W-1:0]       w_slot_data_o,
    output logic [MX_EXP_VECTOR_W-1:0] w_slot_exp_o,
    input  logic                       consume_x_slot_i,
    input  logic                       consume_w_slot_i,
    output logic [31:0]                x_stall_cnt_o,
    output logic [31:0]                w_stall_cnt_o
);

    redmule_mx_slot #(
        .DATA_W    (MX_DATA_W),
        .EXP_W     (MX_X_EXP_W),
        .DEPTH     (SLOT_DEPTH),
        .EXP_REUSE (X_EXP_REUSE)
    ) u_x_slot (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear          (clear_i),
        .enable         (mx_enable_i),
        .man_valid      (x_man_valid_i),
        .man_ready      (x_man_ready_o),
        .man_data       (x_man_data_i),
        .exp_valid      (x_exp_valid_i),
        .exp_ready      (x_exp_ready_o),
        .exp_data       (x_exp_data_i),
        .slot_valid     (x_slot_valid_o),
        .slot_exp_valid (x_slot_exp_valid_o),
        .slot_data      (x_slot_data_o),
        .slot_exp       (x_slot_exp_o),
        .consume        (consume_x_slot_i),
        .stall_cnt      (x_stall_cnt_o)
    );

    redmule_mx_slot #(
        .DATA_W    (MX_DATA_W),
        .EXP_W     (MX_EXP_VECTOR_W),
        .DEPTH     (SLOT_DEPTH),
        .EXP_REUSE (W_EXP_REUSE)
    ) u_w_slot (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear          (clear_i),
        .enable         (mx_enable_i),
        .man_valid      (w_man_valid_i),
        .man_ready      (w_man_ready_o),
        .man_data       (w_man_data_i),
        .exp_valid      (w_exp_valid_i),
        .exp_ready      (w_exp_ready_o),
        .exp_data       (w_exp_data_i),
        .slot_valid     (w_slot_valid_o),
        .slot_exp_valid (w_slot_exp_valid_o),
        .slot_data      (w_slot_data_o),
        .slot_exp       (w_slot_exp_o),
        .consume        (consume_w_slot_i),
        .stall_cnt      (w_stall_cnt_o)
    );

endmodule

// File: tb/tb_redmule_mx_slot_ctrl.sv
// Directed bench for redmule_mx_slot_ctrl: X stream uses exponent reuse 4, W stream reuse 1.
// Stall-counter expectations follow REDMULE_MX_SLOT_PERF_EN.
module tb_redmule_mx_slot_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         mx_enable_i;
    logic         x_man_valid_i, x_man_ready_o;
    logic [255:0] x_man_data_i;
    logic         x_exp_valid_i, x_exp_ready_o;
    logic [7:0]   x_exp_data_i;
    logic         w_man_valid_i, w_man_ready_o;
    logic [255:0] w_man_data_i;
    logic         w_exp_valid_i, w_exp_ready_o;
    logic [31:0]  w_exp_data_i;
    logic         x_slot_valid_o, x_slot_exp_valid_o;
    logic [255:0] x_slot_data_o;
    logic [7:0]   x_slot_exp_o;
    logic         w_slot_valid_o, w_slot_exp_valid_o;
    logic [255:0] w_slot_data_o;
    logic [31:0]  w_slot_exp_o;
    logic         consume_x_slot_i, consume_w_slot_i;
    logic [31:0]  x_stall_cnt_o, w_stall_cnt_o;

    int n_checks = 0;
    int n_fails  = 0;

    redmule_mx_slot_ctrl #(
        .MX_DATA_W       (256),
        .MX_EXP_VECTOR_W (32),
        .SLOT_DEPTH      (2),
        .X_EXP_REUSE     (4),
        .W_EXP_REUSE     (1)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .mx_enable_i        (mx_enable_i),
        .x_man_valid_i      (x_man_valid_i),
        .x_man_ready_o      (x_man_ready_o),
        .x_man_data_i       (x_man_data_i),
        .x_exp_valid_i      (x_exp_valid_i),
        .x_exp_ready_o      (x_exp_ready_o),
        .x_exp_data_i       (x_exp_data_i),
        .w_man_valid_i      (w_man_valid_i),
        .w_man_ready_o      (w_man_ready_o),
        .w_man_data_i       (w_man_data_i),
        .w_exp_valid_i      (w_exp_valid_i),
        .w_exp_ready_o      (w_exp_ready_o),
        .w_exp_data_i       (w_exp_data_i),
        .x_slot_valid_o     (x_slot_valid_o),
        .x_slot_exp_valid_o (x_slot_exp_valid_o),
        .x_slot_data_o      (x_slot_data_o),
        .x_slot_exp_o       (x_slot_exp_o),
        .w_slot_valid_o     (w_slot_valid_o),
        .w_slot_exp_valid_o (w_slot_exp_valid_o),
        .w_slot_data_o      (w_slot_data_o),
        .w_slot_exp_o       (w_slot_exp_o),
        .consume_x_slot_i   (consume_x_slot_i),
        .consume_w_slot_i   (consume_w_slot_i),
        .x_stall_cnt_o      (x_stall_cnt_o),
        .w_stall_cnt_o      (w_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [255:0] pat_a, xb0, xb1, xb2, xb3, wb0, wb1, wb2, xc, xd, we;
    logic [31:0]  exp_stall;

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        xb0 = {8{32'h1000_0000}}; xb1 = {8{32'h1111_1111}};
        xb2 = {8{32'h2222_2222}}; xb3 = {8{32'h3333_3333}};
        wb0 = {8{32'hB000_0000}}; wb1 = {8{32'hB111_1111}}; wb2 = {8{32'hB222_2222}};
        xc  = {8{32'hC0C0_C0C0}}; xd  = {8{32'hD0D0_D0D0}}; we = {8{32'hE0E0_E0E0}};
`ifdef REDMULE_MX_SLOT_PERF_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        rst_ni = 1'b0; clear_i = 1'b0; mx_enable_i = 1'b1;
        x_man_valid_i = 1'b0; x_man_data_i = 256'd0; x_exp_valid_i = 1'b0; x_exp_data_i = 8'd0;
        w_man_valid_i = 1'b0; w_man_data_i = 256'd0; w_exp_valid_i = 1'b0; w_exp_data_i = 32'd0;
        consume_x_slot_i = 1'b0; consume_w_slot_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Reset state and enable gating
        chk("rst_x_man_ready", 256'(x_man_ready_o), 256'(1'b1));
        chk("rst_w_exp_ready", 256'(w_exp_ready_o), 256'(1'b1));
        chk("rst_x_slot_valid", 256'(x_slot_valid_o), 256'(1'b0));
        chk("rst_w_slot_exp_valid", 256'(w_slot_exp_valid_o), 256'(1'b0));
        chk("rst_x_slot_data", x_slot_data_o, 256'd0);
        chk("rst_w_stall", 256'(w_stall_cnt_o), 256'd0);
        mx_enable_i = 1'b0; #1;
        chk("dis_x_man_ready", 256'(x_man_ready_o), 256'(1'b0));
        chk("dis_w_exp_ready", 256'(w_exp_ready_o), 256'(1'b0));
        mx_enable_i = 1'b1; #1;

        // Test 1: W beat + exponent, single-use exponent released on consume
        w_man_valid_i = 1'b1; w_man_data_i = pat_a; w_exp_valid_i = 1'b1; w_exp_data_i = 32'h7F00_0011;
        tick();
        w_man_valid_i = 1'b0; w_exp_valid_i = 1'b0;
        chk("t1_w_valid", 256'(w_slot_valid_o), 256'(1'b1));
        chk("t1_w_exp_valid", 256'(w_slot_exp_valid_o), 256'(1'b1));
        chk("t1_w_data", w_slot_data_o, pat_a);
        chk("t1_w_exp", 256'(w_slot_exp_o), 256'(32'h7F00_0011));
        chk("t1_w_exp_ready", 256'(w_exp_ready_o), 256'(1'b0));
        consume_w_slot_i = 1'b1; tick(); consume_w_slot_i = 1'b0;
        chk("t1_w_valid_after", 256'(w_slot_valid_o), 256'(1'b0));
        chk("t1_w_exp_valid_after", 256'(w_slot_exp_valid_o), 256'(1'b0));
        chk("t1_w_exp_ready_after", 256'(w_exp_ready_o), 256'(1'b1));

        // Test 2: X exponent 0x7F shared over four beats
        x_man_valid_i = 1'b1; x_man_data_i = xb0; x_exp_valid_i = 1'b1; x_exp_data_i = 8'h7F;
        tick();
        x_exp_valid_i = 1'b0; x_man_data_i = xb1;
        chk("t2_x_valid", 256'(x_slot_valid_o), 256'(1'b1));
        chk("t2_x_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b1));
        chk("t2_x_data0", x_slot_data_o, xb0);
        chk("t2_x_exp", 256'(x_slot_exp_o), 256'(8'h7F));
        tick();
        x_man_valid_i = 1'b0;
        chk("t2_x_full_ready", 256'(x_man_ready_o), 256'(1'b0));
        consume_x_slot_i = 1'b1; tick();
        chk("t2_c1_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b1));
        chk("t2_c1_data", x_slot_data_o, xb1);
        chk("t2_c1_ready", 256'(x_man_ready_o), 256'(1'b1));
        x_man_valid_i = 1'b1; x_man_data_i = xb2; tick();
        chk("t2_c2_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b1));
        chk("t2_c2_data", x_slot_data_o, xb2);
        x_man_data_i = xb3; tick();
        x_man_valid_i = 1'b0;
        chk("t2_c3_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b1));
        chk("t2_c3_data", x_slot_data_o, xb3);
        chk("t2_c3_exp_ready", 256'(x_exp_ready_o), 256'(1'b0));
        tick();
        consume_x_slot_i = 1'b0;
        chk("t2_c4_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b0));
        chk("t2_c4_exp_ready", 256'(x_exp_ready_o), 256'(1'b1));
        chk("t2_c4_slot_valid", 256'(x_slot_valid_o), 256'(1'b0));

        // Test 3: W FIFO fills at depth 2, third beat waits for a pop
        w_man_valid_i = 1'b1; w_man_data_i = wb0; tick();
        w_man_data_i = wb1; tick();
        w_man_data_i = wb2;
        chk("t3_w_ready_full", 256'(w_man_ready_o), 256'(1'b0));
        chk("t3_w_head0", w_slot_data_o, wb0);
        w_exp_valid_i = 1'b1; w_exp_data_i = 32'h1234_5678; tick();
        w_exp_valid_i = 1'b0;
        chk("t3_w_head_hold", w_slot_data_o, wb0);
        chk("t3_w_exp_valid", 256'(w_slot_exp_valid_o), 256'(1'b1));
        consume_w_slot_i = 1'b1; tick(); consume_w_slot_i = 1'b0;
        chk("t3_w_ready_after_pop", 256'(w_man_ready_o), 256'(1'b1));
        chk("t3_w_head1", w_slot_data_o, wb1);
        tick();
        w_man_valid_i = 1'b0;
        chk("t3_w_ready_refull", 256'(w_man_ready_o), 256'(1'b0));
        w_exp_valid_i = 1'b1; tick(); w_exp_valid_i = 1'b0;
        consume_w_slot_i = 1'b1; tick(); consume_w_slot_i = 1'b0;
        chk("t3_w_head2", w_slot_data_o, wb2);
        w_exp_valid_i = 1'b1; tick(); w_exp_valid_i = 1'b0;
        consume_w_slot_i = 1'b1; tick(); consume_w_slot_i = 1'b0;
        chk("t3_w_empty", 256'(w_slot_valid_o), 256'(1'b0));

        // Test 4: consume on X without exponent is ignored
        x_man_valid_i = 1'b1; x_man_data_i = xc; tick(); x_man_valid_i = 1'b0;
        chk("t4_x_exp_valid", 256'(x_slot_exp_valid_o), 256'(1'b0));
        consume_x_slot_i = 1'b1; tick(); consume_x_slot_i = 1'b0;
        chk("t4_x_valid_kept", 256'(x_slot_valid_o), 256'(1'b1));
        chk("t4_x_head_kept", x_slot_data_o, xc);
        x_man_valid_i = 1'b1; x_man_data_i = xd; tick(); x_man_valid_i = 1'b0;
        chk("t4_x_count2_full", 256'(x_man_ready_o), 256'(1'b0));
        chk("t4_x_head_order", x_slot_data_o, xc);

        // Test 5: synchronous clear with both streams holding data
        w_man_valid_i = 1'b1; w_man_data_i = wb0; w_exp_valid_i = 1'b1; w_exp_data_i = 32'hCAFE_0001;
        tick();
        w_man_valid_i = 1'b0; w_exp_valid_i = 1'b0;
        chk("t5_w_valid_pre", 256'(w_slot_valid_o), 256'(1'b1));
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("t5_x_valid", 256'(x_slot_valid_o), 256'(1'b0));
        chk("t5_w_valid", 256'(w_slot_valid_o), 256'(1'b0));
        chk("t5_w_exp_valid", 256'(w_slot_exp_valid_o), 256'(1'b0));
        chk("t5_x_man_ready", 256'(x_man_ready_o), 256'(1'b1));
        chk("t5_w_man_ready", 256'(w_man_ready_o), 256'(1'b1));
        chk("t5_x_exp_ready", 256'(x_exp_ready_o), 256'(1'b1));
        chk("t5_w_exp_ready", 256'(w_exp_ready_o), 256'(1'b1));
        chk("t5_x_stall", 256'(x_stall_cnt_o), 256'd0);
        chk("t5_w_stall", 256'(w_stall_cnt_o), 256'd0);
        chk("t5_x_data", x_slot_data_o, 256'd0);
        chk("t5_w_exp", 256'(w_slot_exp_o), 256'd0);

        // Test 6: W mantissa waits 10 cycles for its exponent
        w_man_valid_i = 1'b1; w_man_data_i = we; tick(); w_man_valid_i = 1'b0;
        repeat (10) tick();
        chk("t6_w_stall", 256'(w_stall_cnt_o), 256'(exp_stall));
        chk("t6_x_stall", 256'(x_stall_cnt_o), 256'd0);

        // Disabled cycle holds state despite consume and push requests
        w_exp_valid_i = 1'b1; w_exp_data_i = 32'h0BAD_F00D; tick(); w_exp_valid_i = 1'b0;
        mx_enable_i = 1'b0; consume_w_slot_i = 1'b1; w_man_valid_i = 1'b1; w_man_data_i = wb1;
        tick();
        chk("t7_w_valid_disabled", 256'(w_slot_valid_o), 256'(1'b0));
        mx_enable_i = 1'b1; consume_w_slot_i = 1'b0; w_man_valid_i = 1'b0; #1;
        chk("t7_w_valid_held", 256'(w_slot_valid_o), 256'(1'b1));
        chk("t7_w_head_held", w_slot_data_o, we);
        chk("t7_w_exp_held", 256'(w_slot_exp_valid_o), 256'(1'b1));
        chk("t7_w_ready_one_entry", 256'(w_man_ready_o), 256'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
